// File: rtl/cmd_assembler_if.sv
// ---------------------------------------------------------------------------
// cmd_assembler_if
// Byte-stream input and command-word output bundle for cmd_assembler.
//   rx_valid / rx_data / rx_ready : received-byte handshake (byte taken when
//                                    rx_valid && rx_ready)
//   opcode / config_data          : assembled command, valid while execute
//   execute                       : one-cycle command strobe
//   timeout_err                   : one-cycle strobe, partial command dropped
//   busy                          : long command partially received
// slave  : the assembler side (consumes bytes, produces commands)
// master : the byte source / command sink side
// ---------------------------------------------------------------------------
interface cmd_assembler_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [7:0]  opcode;
  logic [31:0] config_data;
  logic        execute;
  logic        timeout_err;
  logic        busy;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, opcode, config_data, execute, timeout_err, busy
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, opcode, config_data, execute, timeout_err, busy
  );
endinterface

// File: rtl/cmd_assembler.sv
// ---------------------------------------------------------------------------
// cmd_assembler
// Turns the receiver byte stream into SUMP command words for the analyzer
// core. Opcodes with bit 7 clear are single-byte commands; opcodes with bit 7
// set are followed by four argument bytes, least-significant byte first.
// A partial long command is discarded if the gap between its bytes reaches
// TIMEOUT cycles, so a glitched host link cannot shift the command framing.
//
// Parameters:
//   TIMEOUT : max sys_clk cycles between bytes of a long command (0 = never)
//   TW      : timeout counter width, 2**TW > TIMEOUT
// Ports:
//   sys_clk : core clock, rising edge
//   sys_rst : asynchronous active-high reset
//   bus     : cmd_assembler_if.slave (byte handshake in, command out)
// ---------------------------------------------------------------------------
module cmd_assembler #(
  parameter int TIMEOUT = 100000,
  parameter int TW      = 17
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  cmd_assembler_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, DATA, EXEC} state_t;

  // Counter value at which an idle gap expires; unused when TIMEOUT is 0.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [1:0]    byte_cnt, byte_cnt_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic          to_err_q, to_err_nxt;
  logic [7:0]    opcode_q;
  logic [31:0]   cfg_q;
  logic          rdy;
  logic          accept;
  logic          load_op;
  logic          load_cfg;

  // The only stall is the single EXEC cycle.
  assign rdy    = (state != EXEC);
  assign accept = bus.rx_valid && rdy;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      byte_cnt <= 2'd0;
      to_cnt   <= '0;
      to_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      to_cnt   <= to_cnt_nxt;
      to_err_q <= to_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    to_cnt_nxt   = to_cnt;
    to_err_nxt   = 1'b0;
    load_op      = 1'b0;
    load_cfg     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load_op = 1'b1;
          if (bus.rx_data[7]) begin
            state_nxt    = DATA;
            byte_cnt_nxt = 2'd0;
            to_cnt_nxt   = '0;
          end else begin
            state_nxt = EXEC;
          end
        end
      end
      DATA: begin
        // A byte arriving in the expiry cycle takes priority over the timeout.
        if (accept) begin
          load_cfg     = 1'b1;
          to_cnt_nxt   = '0;
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state_nxt = EXEC;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
          if ((TIMEOUT != 0) && (to_cnt_nxt == TO_LAST)) begin
            state_nxt  = IDLE;
            to_err_nxt = 1'b1;
          end
        end
      end
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command registers hold until overwritten by the next command's bytes.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      opcode_q <= 8'h00;
      cfg_q    <= 32'h0;
    end else begin
      if (load_op)  opcode_q <= bus.rx_data;
      if (load_cfg) cfg_q[{byte_cnt, 3'b000} +: 8] <= bus.rx_data;
    end
  end

  assign bus.rx_ready    = rdy;
  assign bus.opcode      = opcode_q;
  assign bus.config_data = cfg_q;
  assign bus.execute     = (state == EXEC);
  assign bus.busy        = (state == DATA);
  assign bus.timeout_err = to_err_q;

endmodule

// File: tb/tb_cmd_assembler.sv
// ---------------------------------------------------------------------------
// tb_cmd_assembler
// Directed bench for cmd_assembler. dut_a uses TIMEOUT=16; dut_b has the
// timeout disabled (TIMEOUT=0) with a narrow counter so a long gap wraps it.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point.
// ---------------------------------------------------------------------------
module tb_cmd_assembler;

  logic sys_clk;
  logic sys_rst;
  int   errs;
  int   checks;

  cmd_assembler_if if_a();
  cmd_assembler_if if_b();

  cmd_assembler #(.TIMEOUT(16), .TW(5)) dut_a (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (if_a.slave)
  );

  cmd_assembler #(.TIMEOUT(0), .TW(4)) dut_b (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (if_b.slave)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (if_a.opcode !== 8'h00) begin errs++; $display("FAIL reset_opcode: got %h want 00", if_a.opcode); end
    checks++; if (if_a.config_data !== 32'h0) begin errs++; $display("FAIL reset_cfg: got %h want 00000000", if_a.config_data); end
    checks++; if (if_a.execute !== 1'b0) begin errs++; $display("FAIL reset_execute: got %b want 0", if_a.execute); end
    checks++; if (if_a.timeout_err !== 1'b0) begin errs++; $display("FAIL reset_timeout_err: got %b want 0", if_a.timeout_err); end
    checks++; if (if_a.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", if_a.busy); end
    checks++; if (if_a.rx_ready !== 1'b1) begin errs++; $display("FAIL reset_rx_ready: got %b want 1", if_a.rx_ready); end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    step();
  endtask

  task automatic test_short();
    if_a.rx_valid = 1'b1; if_a.rx_data = 8'h01;
    step();
    if_a.rx_valid = 1'b0; if_a.rx_data = 8'hFF;
    checks++; if (if_a.execute !== 1'b1) begin errs++; $display("FAIL short_execute: got %b want 1", if_a.execute); end
    checks++; if (if_a.opcode !== 8'h01) begin errs++; $display("FAIL short_opcode: got %h want 01", if_a.opcode); end
    checks++; if (if_a.config_data !== 32'h0) begin errs++; $display("FAIL short_cfg: got %h want 00000000", if_a.config_data); end
    checks++; if (if_a.rx_ready !== 1'b0) begin errs++; $display("FAIL short_rx_ready: got %b want 0", if_a.rx_ready); end
    step();
    checks++; if (if_a.execute !== 1'b0) begin errs++; $display("FAIL short_exec_width: got %b want 0", if_a.execute); end
    checks++; if (if_a.rx_ready !== 1'b1) begin errs++; $display("FAIL short_ready_back: got %b want 1", if_a.rx_ready); end
  endtask

  task automatic test_long();
    logic [7:0] bytes [5];
    bytes = '{8'hC0, 8'h78, 8'h56, 8'h34, 8'h12};
    for (int i = 0; i < 5; i++) begin
      if_a.rx_valid = 1'b1; if_a.rx_data = bytes[i];
      step();
      if (i < 4) begin
        checks++; if (if_a.busy !== 1'b1) begin errs++; $display("FAIL long_busy[%0d]: got %b want 1", i, if_a.busy); end
        checks++; if (if_a.execute !== 1'b0) begin errs++; $display("FAIL long_early_exec[%0d]: got %b want 0", i, if_a.execute); end
      end
    end
    if_a.rx_valid = 1'b0;
    checks++; if (if_a.execute !== 1'b1) begin errs++; $display("FAIL long_execute: got %b want 1", if_a.execute); end
    checks++; if (if_a.busy !== 1'b0) begin errs++; $display("FAIL long_busy_exec: got %b want 0", if_a.busy); end
    checks++; if (if_a.opcode !== 8'hC0) begin errs++; $display("FAIL long_opcode: got %h want c0", if_a.opcode); end
    checks++; if (if_a.config_data !== 32'h12345678) begin errs++; $display("FAIL long_cfg: got %h want 12345678", if_a.config_data); end
    step();
    checks++; if (if_a.execute !== 1'b0) begin errs++; $display("FAIL long_exec_width: got %b want 0", if_a.execute); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] stream [3];
    logic       exp_exec [6];
    logic [7:0] exp_op [6];
    logic       acc;
    int         idx;
    stream   = '{8'h02, 8'h03, 8'h04};
    exp_exec = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_op   = '{8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
    idx = 0;
    if_a.rx_valid = 1'b1; if_a.rx_data = stream[0];
    for (int c = 0; c < 6; c++) begin
      acc = if_a.rx_valid && if_a.rx_ready;
      step();
      if (acc) idx++;
      if_a.rx_valid = (idx < 3);
      if_a.rx_data  = (idx < 3) ? stream[idx] : 8'h00;
      checks++; if (if_a.execute !== exp_exec[c]) begin errs++; $display("FAIL b2b_execute[%0d]: got %b want %b", c, if_a.execute, exp_exec[c]); end
      checks++; if (if_a.rx_ready !== !exp_exec[c]) begin errs++; $display("FAIL b2b_rx_ready[%0d]: got %b want %b", c, if_a.rx_ready, !exp_exec[c]); end
      if (exp_exec[c]) begin
        checks++; if (if_a.opcode !== exp_op[c]) begin errs++; $display("FAIL b2b_opcode[%0d]: got %h want %h", c, if_a.opcode, exp_op[c]); end
      end
    end
    if_a.rx_valid = 1'b0;
    checks++; if (idx !== 3) begin errs++; $display("FAIL b2b_accepted: got %0d want 3", idx); end
  endtask

  task automatic test_timeout();
    if_a.rx_valid = 1'b1; if_a.rx_data = 8'h81;
    step();
    if_a.rx_data = 8'hAA;
    step();
    if_a.rx_valid = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step();
      checks++; if (if_a.timeout_err !== (k == 15)) begin errs++; $display("FAIL timeout_err[%0d]: got %b want %b", k, if_a.timeout_err, (k == 15)); end
      checks++; if (if_a.busy !== (k < 15)) begin errs++; $display("FAIL timeout_busy[%0d]: got %b want %b", k, if_a.busy, (k < 15)); end
      checks++; if (if_a.execute !== 1'b0) begin errs++; $display("FAIL timeout_exec[%0d]: got %b want 0", k, if_a.execute); end
    end
    checks++; if (if_a.opcode !== 8'h81) begin errs++; $display("FAIL timeout_hold_op: got %h want 81", if_a.opcode); end
    checks++; if (if_a.config_data !== 32'h123456AA) begin errs++; $display("FAIL timeout_hold_cfg: got %h want 123456aa", if_a.config_data); end
    if_a.rx_valid = 1'b1; if_a.rx_data = 8'h11;
    step();
    if_a.rx_valid = 1'b0;
    checks++; if (if_a.execute !== 1'b1) begin errs++; $display("FAIL timeout_next_exec: got %b want 1", if_a.execute); end
    checks++; if (if_a.opcode !== 8'h11) begin errs++; $display("FAIL timeout_next_op: got %h want 11", if_a.opcode); end
    step();
  endtask

  task automatic test_boundary();
    logic [7:0] tail [3];
    tail = '{8'hBB, 8'hCC, 8'hDD};
    if_a.rx_valid = 1'b1; if_a.rx_data = 8'h81;
    step();
    if_a.rx_data = 8'hAA;
    step();
    if_a.rx_valid = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      checks++; if (if_a.timeout_err !== 1'b0) begin errs++; $display("FAIL bound_gap_err[%0d]: got %b want 0", k, if_a.timeout_err); end
    end
    for (int i = 0; i < 3; i++) begin
      if_a.rx_valid = 1'b1; if_a.rx_data = tail[i];
      step();
      checks++; if (if_a.timeout_err !== 1'b0) begin errs++; $display("FAIL bound_err[%0d]: got %b want 0", i, if_a.timeout_err); end
      if (i < 2) begin
        checks++; if (if_a.busy !== 1'b1) begin errs++; $display("FAIL bound_busy[%0d]: got %b want 1", i, if_a.busy); end
      end
    end
    if_a.rx_valid = 1'b0;
    checks++; if (if_a.execute !== 1'b1) begin errs++; $display("FAIL bound_exec: got %b want 1", if_a.execute); end
    checks++; if (if_a.opcode !== 8'h81) begin errs++; $display("FAIL bound_opcode: got %h want 81", if_a.opcode); end
    checks++; if (if_a.config_data !== 32'hDDCCBBAA) begin errs++; $display("FAIL bound_cfg: got %h want ddccbbaa", if_a.config_data); end
    step();
  endtask

  task automatic test_no_timeout();
    logic [7:0] head [3];
    int bad;
    head = '{8'h90, 8'h01, 8'h02};
    for (int i = 0; i < 3; i++) begin
      if_b.rx_valid = 1'b1; if_b.rx_data = head[i];
      step();
    end
    if_b.rx_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (if_b.busy !== 1'b1 || if_b.timeout_err !== 1'b0 || if_b.execute !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errs++; $display("FAIL notimeout_gap: got %0d bad cycles want 0", bad); end
    if_b.rx_valid = 1'b1; if_b.rx_data = 8'h03;
    step();
    if_b.rx_data = 8'h04;
    step();
    if_b.rx_valid = 1'b0;
    checks++; if (if_b.execute !== 1'b1) begin errs++; $display("FAIL notimeout_exec: got %b want 1", if_b.execute); end
    checks++; if (if_b.opcode !== 8'h90) begin errs++; $display("FAIL notimeout_opcode: got %h want 90", if_b.opcode); end
    checks++; if (if_b.config_data !== 32'h04030201) begin errs++; $display("FAIL notimeout_cfg: got %h want 04030201", if_b.config_data); end
    step();
  endtask

  task automatic test_async_reset();
    logic [7:0] part [3];
    part = '{8'h83, 8'h01, 8'h02};
    for (int i = 0; i < 3; i++) begin
      if_a.rx_valid = 1'b1; if_a.rx_data = part[i];
      step();
    end
    if_a.rx_valid = 1'b0;
    checks++; if (if_a.busy !== 1'b1) begin errs++; $display("FAIL arst_pre_busy: got %b want 1", if_a.busy); end
    #2;
    sys_rst = 1'b1;
    #1;
    checks++; if (if_a.busy !== 1'b0) begin errs++; $display("FAIL arst_busy: got %b want 0", if_a.busy); end
    checks++; if (if_a.opcode !== 8'h00) begin errs++; $display("FAIL arst_opcode: got %h want 00", if_a.opcode); end
    checks++; if (if_a.config_data !== 32'h0) begin errs++; $display("FAIL arst_cfg: got %h want 00000000", if_a.config_data); end
    checks++; if (if_a.rx_ready !== 1'b1) begin errs++; $display("FAIL arst_rx_ready: got %b want 1", if_a.rx_ready); end
    step();
    #2;
    sys_rst = 1'b0;
    step();
    checks++; if (if_a.execute !== 1'b0) begin errs++; $display("FAIL arst_no_exec: got %b want 0", if_a.execute); end
    if_a.rx_valid = 1'b1; if_a.rx_data = 8'h05;
    step();
    if_a.rx_valid = 1'b0;
    checks++; if (if_a.execute !== 1'b1) begin errs++; $display("FAIL arst_next_exec: got %b want 1", if_a.execute); end
    checks++; if (if_a.opcode !== 8'h05) begin errs++; $display("FAIL arst_next_op: got %h want 05", if_a.opcode); end
    checks++; if (if_a.config_data !== 32'h0) begin errs++; $display("FAIL arst_next_cfg: got %h want 00000000", if_a.config_data); end
    step();
  endtask

  initial begin
    errs          = 0;
    checks        = 0;
    sys_clk       = 1'b0;
    sys_rst       = 1'b1;
    if_a.rx_valid = 1'b0;
    if_a.rx_data  = 8'h00;
    if_b.rx_valid = 1'b0;
    if_b.rx_data  = 8'h00;

    test_reset();
    test_short();
    test_long();
    test_back_to_back();
    test_timeout();
    test_boundary();
    test_no_timeout();
    test_async_reset();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cmd_assembler.md
Name: cmd_assembler

Overview:
Upstream neighbour of the analyzer core. Converts the byte stream from the UART/SPI receiver into SUMP command words and drives the core's opcode, config_data and execute inputs.
- Short commands (opcode bit 7 = 0) are one byte.
- Long commands (opcode bit 7 = 1) are one opcode byte followed by four data bytes, least-significant byte first.
- An inter-byte timeout discards partial long commands, so a glitched host link cannot desynchronise the command framing.

Parameters:
TIMEOUT, 100000, maximum number of sys_clk cycles between consecutive bytes of a long command; 0 disables the timeout.
TW, 17, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
sys_clk  input  1  core clock; all logic is on its rising edge.
sys_rst  input  1  asynchronous active-high reset.
rx_valid  input  1  received byte valid.
rx_data  input  8  received byte.
rx_ready  output  1  byte accepted when rx_valid && rx_ready.
opcode  output  8  command opcode to the core.
config_data  output  32  command argument to the core.
execute  output  1  one-cycle strobe; opcode and config_data are valid.
timeout_err  output  1  one-cycle strobe; a partial long command was discarded.
busy  output  1  high while a long command is partially received.

Behaviour:
- Reset (asynchronous, on sys_rst high) sets:
  - state to IDLE;
  - opcode = 8'h00, config_data = 32'h0;
  - execute = 0, timeout_err = 0, busy = 0, rx_ready = 1;
  - byte counter = 0, timeout counter = 0.
- Reset asserted mid-command: the partial command is dropped and no execute is issued.
- States: IDLE, DATA, EXEC.
- IDLE, on an accepted byte:
  - the byte loads into opcode;
  - bit 7 = 0: go to EXEC;
  - bit 7 = 1: go to DATA, clear the byte counter and the timeout counter.
- DATA, on an accepted byte:
  - byte n (n = 0..3) loads into config_data[8n+7:8n]; other bytes of config_data are held;
  - the timeout counter clears;
  - the byte counter increments, 2 bits wide;
  - after byte n = 3, go to EXEC.
- DATA, no byte accepted this cycle:
  - the timeout counter increments;
  - if TIMEOUT != 0 and the counter equals TIMEOUT-1, go to IDLE and pulse timeout_err for one cycle;
  - opcode and config_data keep whatever was partially loaded, and execute is not asserted.
- Byte acceptance and timeout expiry in the same cycle: the byte wins and the counter clears.
- EXEC lasts one cycle:
  - execute = 1 and rx_ready = 0;
  - next state is IDLE.
- Latency: execute is high in the cycle after the final byte is accepted.
- Short commands leave config_data unchanged from the previous command.
- Output holding: opcode and config_data are registered and hold their values until overwritten by the next command's bytes. The core samples them only while execute is high.
- Output timing:
  - rx_ready = 0 only in EXEC; otherwise 1;
  - busy = 1 exactly while in DATA.
- Throughput: at most one byte per cycle. Back-to-back bytes with rx_valid held high are accepted in every cycle except EXEC.
  - Minimum short-command period: 2 cycles.
  - Minimum long-command period: 6 cycles.
- rx_data is ignored when rx_valid = 0. No byte is ever lost or duplicated across the EXEC stall.
- Reset-command robustness: five 0x00 bytes produce five separate execute pulses with opcode 0x00. The core's decoder handles the reset from there.

Test Plan:
- Short command: after reset, send byte 0x01 → one cycle later execute = 1 for exactly 1 cycle, opcode = 0x01, config_data = 0x00000000, and rx_ready = 0 in that cycle.
- Long command: send 0xC0, 0x78, 0x56, 0x34, 0x12 back-to-back → execute one cycle after the 0x12 byte, opcode = 0xC0, config_data = 0x12345678; busy high for the 4 cycles in DATA.
- Stall: hold rx_valid = 1 with a stream of 0x02, 0x03, 0x04 → three execute pulses, opcodes 0x02, 0x03, 0x04 in order; rx_ready low only in each EXEC cycle; no byte lost.
- Timeout: with TIMEOUT = 16, send 0x81, 0xAA, then idle → timeout_err pulses once, 15 cycles after the 0xAA byte is accepted; no execute; the next byte 0x11 is treated as a short opcode and executes.
- Boundary: with TIMEOUT = 16, deliver the next byte exactly at the expiry cycle → no timeout_err, and the long command completes normally. With TIMEOUT = 0 and a 10^6-cycle gap, the command still completes.
- Asynchronous reset mid-command: pulse sys_rst after 2 data bytes, not aligned to a clock edge → outputs are at reset values immediately; no execute; a following 0x05 executes cleanly with opcode = 0x05.
